ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  EX-end pipeline controller: reads the ID/EX latched bundle plus ALU branch result and drives
//  stall/flush/hold back to IF, IF/ID and ID/EX. Handles load-use bubbles, taken-branch/jump
//  redirect flushes and multi-cycle multiply occupancy; keeps saturating stall/flush perf counters.
// PARAMETERS
//  MUL_CYCLES  8   EX occupancy of one multiply in cycles; legal range 1..255 (1 = no stall)
//  CNT_WIDTH   32  width of each performance counter
// PORTS
//  clk            in   1          rising-edge clock
//  rst_n          in   1          asynchronous, active-low reset
//  EX_MemRead     in   1          instruction in EX is a load
//  EX_RegWrite    in   1          instruction in EX writes rd
//  EX_rdReg       in   5          destination register of instruction in EX
//  EX_Branch      in   1          instruction in EX is a conditional branch
//  EX_Jump        in   1          instruction in EX is jal/jalr
//  EX_BrTaken     in   1          ALU compare result for the branch in EX
//  EX_MulStart    in   1          instruction in EX is a multiply (valid in RUN only)
//  ID_rs1Reg      in   5          rs1 of instruction in ID
//  ID_rs2Reg      in   5          rs2 of instruction in ID
//  ID_UsesRs1     in   1          ID instruction reads rs1
//  ID_UsesRs2     in   1          ID instruction reads rs2
//  PCWrite        out  1          PC register enable
//  PCSrc          out  1          1 = load PC with branch/jump target
//  IFID_Write     out  1          IF/ID register enable
//  IFID_Flush     out  1          zero IF/ID contents at next edge
//  IDEX_Flush     out  1          load bubble (all controls 0) into ID/EX at next edge
//  IDEX_Hold      out  1          ID/EX keeps current contents
//  EX_Busy        out  1          multiply occupying EX
//  MulDone        out  1          one-cycle pulse on last multiply cycle
//  StallCount     out  CNT_WIDTH  cycles with PCWrite=0 due to load-use or multiply
//  FlushCount     out  CNT_WIDTH  number of redirect events
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, busy counter=0, StallCount=FlushCount=0; while asserted
//   PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, PCSrc=0, IDEX_Hold=0, EX_Busy=0, MulDone=0.
//  States: RUN, MUL_BUSY. Control outputs are combinational from state+inputs (zero latency);
//   counters and state update at posedge clk.
//  RUN, priority redirect > multiply > load-use; defaults PCWrite=1, IFID_Write=1, all others 0.
//   redirect = EX_Jump | (EX_Branch & EX_BrTaken): PCSrc=1, IFID_Flush=1, IDEX_Flush=1,
//    FlushCount+=1. Stays RUN (single-cycle redirect).
//   multiply = EX_MulStart & MUL_CYCLES>1: PCWrite=0, IFID_Write=0, IDEX_Hold=1, EX_Busy=1;
//    counter<=MUL_CYCLES-2; next state MUL_BUSY. MUL_CYCLES==1: MulDone=1 this cycle, no stall.
//   load-use = EX_MemRead & EX_rdReg!=0 & ((ID_UsesRs1 & rs1==rd)|(ID_UsesRs2 & rs2==rd)):
//    PCWrite=0, IFID_Write=0, IDEX_Flush=1 (one bubble). Next cycle EX holds the bubble, so no
//    re-detection.
//  MUL_BUSY: PCWrite=0, IFID_Write=0, IDEX_Hold=1, EX_Busy=1; counter decrements each cycle.
//   On counter==0: MulDone=1, PCWrite=1, IFID_Write=1, IDEX_Hold=0, EX_Busy=0; next RUN.
//   Total EX occupancy = MUL_CYCLES cycles; stalled PC cycles = MUL_CYCLES-1.
//   Load-use, redirect and EX_MulStart are ignored in MUL_BUSY.
//  IDEX_Flush and IDEX_Hold never both 1; IFID_Flush=1 implies IFID_Write=1.
//  StallCount += 1 on every clock edge with PCWrite=0 outside reset. Both counters saturate at
//   all-ones.
//  Reset mid-multiply: immediate abort to RUN, MulDone not pulsed, counters cleared.
// STRUCTURE
//  Package pipe_ctrl_pkg: state encoding (RUN=1'b0, MUL_BUSY=1'b1), REG_X0=5'd0, and the
//   ID/EX bubble control constant (all-zero control word).
//  Sub-module sat_counter #(CNT_WIDTH) (clk, rst_n, inc, count), instantiated twice for the
//   perf counters. FSM and busy counter stay inline.
// TESTING
//  1 Load x5 in EX (MemRead=1,rd=5); ID rs1=5,UsesRs1=1 -> PCWrite=0,IFID_Write=0,IDEX_Flush=1
//    for exactly 1 cycle; StallCount=1.
//  2 Same as 1 but rd=0, or UsesRs1=0 -> no stall, PCWrite=1, StallCount stays 0.
//  3 EX_Branch=1,EX_BrTaken=1 -> PCSrc=1,IFID_Flush=1,IDEX_Flush=1 same cycle; FlushCount=1;
//    BrTaken=0 -> no flush.
//  4 MUL_CYCLES=8, EX_MulStart pulse -> EX_Busy high 7 cycles, MulDone on 8th, PCWrite=0 for 7,
//    StallCount=7.
//  5 Redirect + load-use match in the same cycle -> redirect only (PCSrc=1), StallCount
//    unchanged.
//  6 rst_n low in cycle 3 of a multiply -> outputs at reset values immediately; after release,
//    RUN, counters 0.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Brief    : Shared types and constants for the EX-stage hazard controller:
//             FSM state encoding, the x0 register index and the pipeline
//             control word (all-zero word doubles as the ID/EX bubble).
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller states: normal issue, or EX occupied by a multi-cycle multiply.
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    // Register x0 is hard-wired to zero and never creates a dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Pipeline control word driven back to IF, IF/ID and ID/EX.
    typedef struct packed {
        logic pc_write;
        logic pc_src;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic idex_hold;
        logic ex_busy;
        logic mul_done;
    } ctrl_t;

    // All-zero control word: the bubble loaded into ID/EX, and the base from
    // which every cycle's control word is built.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Control word held while rst_n is asserted: front end frozen and flushed.
    localparam ctrl_t CTRL_RESET = '{
        pc_write:   1'b0,
        pc_src:     1'b0,
        ifid_write: 1'b0,
        ifid_flush: 1'b1,
        idex_flush: 1'b1,
        idex_hold:  1'b0,
        ex_busy:    1'b0,
        mul_done:   1'b0
    };

endpackage
`default_nettype wire

// File: rtl/ex_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_hazard_ctrl_if
//  Brief    : Bundle between the ID/EX latch + ALU and the hazard controller,
//             carrying the EX/ID decode fields in and pipeline controls and
//             performance counters out.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_hazard_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    // Instruction in EX
    logic                 EX_MemRead;
    logic                 EX_RegWrite;
    logic [4:0]           EX_rdReg;
    logic                 EX_Branch;
    logic                 EX_Jump;
    logic                 EX_BrTaken;
    logic                 EX_MulStart;
    // Instruction in ID
    logic [4:0]           ID_rs1Reg;
    logic [4:0]           ID_rs2Reg;
    logic                 ID_UsesRs1;
    logic                 ID_UsesRs2;
    // Pipeline controls
    logic                 PCWrite;
    logic                 PCSrc;
    logic                 IFID_Write;
    logic                 IFID_Flush;
    logic                 IDEX_Flush;
    logic                 IDEX_Hold;
    logic                 EX_Busy;
    logic                 MulDone;
    // Performance counters
    logic [CNT_WIDTH-1:0] StallCount;
    logic [CNT_WIDTH-1:0] FlushCount;

    // Pipeline side: presents decode fields, consumes controls.
    modport master (
        output EX_MemRead, EX_RegWrite, EX_rdReg, EX_Branch, EX_Jump,
               EX_BrTaken, EX_MulStart, ID_rs1Reg, ID_rs2Reg, ID_UsesRs1,
               ID_UsesRs2,
        input  PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, IDEX_Hold,
               EX_Busy, MulDone, StallCount, FlushCount
    );

    // Controller side.
    modport slave (
        input  EX_MemRead, EX_RegWrite, EX_rdReg, EX_Branch, EX_Jump,
               EX_BrTaken, EX_MulStart, ID_rs1Reg, ID_rs2Reg, ID_UsesRs1,
               ID_UsesRs2,
        output PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, IDEX_Hold,
               EX_Busy, MulDone, StallCount, FlushCount
    );
endinterface
`default_nettype wire

// File: rtl/ex_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Event counter that increments on each enabled clock edge and
//             sticks at all-ones instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 inc,
    output logic      [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;

    // Count events, holding at the maximum value once reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ex_hazard_ctrl
//  Brief    : EX-end pipeline controller. Resolves redirect flushes, multiply
//             occupancy and load-use bubbles into stall/flush/hold controls,
//             and keeps saturating stall and flush performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module ex_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ex_hazard_ctrl_if.slave bus
);

    // First busy-counter value: the RUN cycle that accepts the multiply is
    // the first occupied cycle, and the done cycle is entered at zero.
    localparam logic [7:0] MUL_LOAD = (MUL_CYCLES > 1) ? 8'(MUL_CYCLES - 2) : 8'd0;

    state_t     state_q, state_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;
    ctrl_t      ctrl;
    logic       redirect;
    logic       load_use;
    logic       redirect_evt;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    // Hazard detection on the raw EX/ID fields.
    always_comb begin
        redirect = bus.EX_Jump | (bus.EX_Branch & bus.EX_BrTaken);
        load_use = bus.EX_MemRead && (bus.EX_rdReg != REG_X0) &&
                   ((bus.ID_UsesRs1 && (bus.ID_rs1Reg == bus.EX_rdReg)) ||
                    (bus.ID_UsesRs2 && (bus.ID_rs2Reg == bus.EX_rdReg)));
    end

    // Next state, busy counter and zero-latency control outputs.
    always_comb begin
        ctrl            = CTRL_BUBBLE;
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;
        state_d         = state_q;
        busy_cnt_d      = busy_cnt_q;
        redirect_evt    = 1'b0;

        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        ctrl.pc_src     = 1'b1;
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                        redirect_evt    = 1'b1;
                    end else if (bus.EX_MulStart && (MUL_CYCLES > 1)) begin
                        ctrl.pc_write   = 1'b0;
                        ctrl.ifid_write = 1'b0;
                        ctrl.idex_hold  = 1'b1;
                        ctrl.ex_busy    = 1'b1;
                        busy_cnt_d      = MUL_LOAD;
                        state_d         = ST_MUL_BUSY;
                    end else begin
                        // Single-cycle multiply completes in place.
                        ctrl.mul_done = bus.EX_MulStart;
                        if (load_use) begin
                            ctrl.pc_write   = 1'b0;
                            ctrl.ifid_write = 1'b0;
                            ctrl.idex_flush = 1'b1;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    if (busy_cnt_q == 8'd0) begin
                        ctrl.mul_done = 1'b1;
                        state_d       = ST_RUN;
                    end else begin
                        ctrl.pc_write   = 1'b0;
                        ctrl.ifid_write = 1'b0;
                        ctrl.idex_hold  = 1'b1;
                        ctrl.ex_busy    = 1'b1;
                        busy_cnt_d      = busy_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and multiply busy counter; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            busy_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl.pc_write),
        .count (stall_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_evt),
        .count (flush_count)
    );

    assign bus.PCWrite    = ctrl.pc_write;
    assign bus.PCSrc      = ctrl.pc_src;
    assign bus.IFID_Write = ctrl.ifid_write;
    assign bus.IFID_Flush = ctrl.ifid_flush;
    assign bus.IDEX_Flush = ctrl.idex_flush;
    assign bus.IDEX_Hold  = ctrl.idex_hold;
    assign bus.EX_Busy    = ctrl.ex_busy;
    assign bus.MulDone    = ctrl.mul_done;
    assign bus.StallCount = stall_count;
    assign bus.FlushCount = flush_count;

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_hazard_ctrl
//  Brief    : Self-checking bench for ex_hazard_ctrl: directed scenarios then
//             randomized traffic against a cycle-level behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_hazard_ctrl;

    localparam int unsigned MUL_CYCLES = 8;
    localparam int unsigned CNT_WIDTH  = 32;

    // Expected control words: {PCWrite,PCSrc,IFID_Write,IFID_Flush,
    //                          IDEX_Flush,IDEX_Hold,EX_Busy,MulDone}
    localparam logic [7:0] V_RESET     = 8'b0001_1000;
    localparam logic [7:0] V_RUN       = 8'b1010_0000;
    localparam logic [7:0] V_REDIRECT  = 8'b1111_1000;
    localparam logic [7:0] V_LOADUSE   = 8'b0000_1000;
    localparam logic [7:0] V_MUL_STALL = 8'b0000_0110;
    localparam logic [7:0] V_MUL_DONE  = 8'b1010_0001;

    logic clk;
    logic rst_n;

    ex_hazard_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    ex_hazard_ctrl #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    string       scen;

    // Model state: occupancy cycles still owed to the current multiply and
    // the two perf counts.
    int unsigned m_mul_left;
    logic [CNT_WIDTH-1:0] m_stall;
    logic [CNT_WIDTH-1:0] m_flush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL [%s/%s] got=%0h expected=%0h at %0t", scen, tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.EX_MemRead  = 1'b0;
        bus.EX_RegWrite = 1'b0;
        bus.EX_rdReg    = 5'd0;
        bus.EX_Branch   = 1'b0;
        bus.EX_Jump     = 1'b0;
        bus.EX_BrTaken  = 1'b0;
        bus.EX_MulStart = 1'b0;
        bus.ID_rs1Reg   = 5'd0;
        bus.ID_rs2Reg   = 5'd0;
        bus.ID_UsesRs1  = 1'b0;
        bus.ID_UsesRs2  = 1'b0;
    endtask

    // Inputs were set just after a falling edge: compare against the model,
    // advance the model across the coming rising edge, go to the next falling edge.
    task automatic step();
        logic [7:0] e;
        logic [7:0] got;
        logic       redir;
        logic       lu;
        logic       mul_acc;
        #1;
        if (!rst_n) begin
            m_mul_left = 0;
            m_stall    = '0;
            m_flush    = '0;
        end
        redir   = bus.EX_Jump | (bus.EX_Branch & bus.EX_BrTaken);
        lu      = bus.EX_MemRead && (bus.EX_rdReg != 5'd0) &&
                  ((bus.ID_UsesRs1 && bus.ID_rs1Reg == bus.EX_rdReg) ||
                   (bus.ID_UsesRs2 && bus.ID_rs2Reg == bus.EX_rdReg));
        mul_acc = 1'b0;
        if (!rst_n)                e = V_RESET;
        else if (m_mul_left > 1)   e = V_MUL_STALL;
        else if (m_mul_left == 1)  e = V_MUL_DONE;
        else if (redir)            e = V_REDIRECT;
        else if (bus.EX_MulStart && MUL_CYCLES > 1) begin
            e       = V_MUL_STALL;
            mul_acc = 1'b1;
        end else begin
            e = lu ? V_LOADUSE : V_RUN;
            if (bus.EX_MulStart) e[0] = 1'b1;
        end

        got = {bus.PCWrite, bus.PCSrc, bus.IFID_Write, bus.IFID_Flush,
               bus.IDEX_Flush, bus.IDEX_Hold, bus.EX_Busy, bus.MulDone};
        check("ctrl", 64'(got), 64'(e));
        check("StallCount", 64'(bus.StallCount), 64'(m_stall));
        check("FlushCount", 64'(bus.FlushCount), 64'(m_flush));

        if (rst_n) begin
            if (!e[7] && m_stall != '1) m_stall = m_stall + 1'b1;
            if (m_mul_left == 0 && redir && m_flush != '1) m_flush = m_flush + 1'b1;
            if (m_mul_left > 0) m_mul_left = m_mul_left - 1;
            else if (mul_acc)   m_mul_left = MUL_CYCLES - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_mul_left = 0;
        m_stall    = '0;
        m_flush    = '0;
        scen       = "reset";
        rst_n      = 1'b0;
        idle_inputs();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Load-use on rs1 gives exactly one bubble cycle.
        scen = "loaduse";
        bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_rdReg = 5'd5;
        bus.ID_rs1Reg = 5'd5; bus.ID_UsesRs1 = 1'b1;
        step();
        idle_inputs();
        step();
        check("StallCount_after_lu", 64'(bus.StallCount), 64'd1);

        // No dependency through x0 or an unused source.
        scen = "no_loaduse";
        bus.EX_MemRead = 1'b1; bus.EX_rdReg = 5'd0;
        bus.ID_rs1Reg = 5'd0; bus.ID_UsesRs1 = 1'b1;
        step();
        bus.EX_rdReg = 5'd5; bus.ID_rs1Reg = 5'd5; bus.ID_UsesRs1 = 1'b0;
        step();
        bus.ID_rs2Reg = 5'd5; bus.ID_UsesRs2 = 1'b1;
        step();
        idle_inputs();
        step();

        // Taken branch redirects; not-taken does not.
        scen = "branch";
        bus.EX_Branch = 1'b1; bus.EX_BrTaken = 1'b1;
        step();
        bus.EX_BrTaken = 1'b0;
        step();
        idle_inputs();
        step();
        check("FlushCount_after_br", 64'(bus.FlushCount), 64'd1);

        // Multiply occupies EX for MUL_CYCLES cycles.
        scen = "mul";
        bus.EX_MulStart = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < int'(MUL_CYCLES); i++) step();

        // Redirect wins over a simultaneous load-use.
        scen = "redir_vs_lu";
        bus.EX_Jump = 1'b1; bus.EX_MemRead = 1'b1; bus.EX_rdReg = 5'd7;
        bus.ID_rs2Reg = 5'd7; bus.ID_UsesRs2 = 1'b1;
        step();
        idle_inputs();
        step();

        // Reset asserted in the third multiply cycle aborts it.
        scen = "mul_reset";
        bus.EX_MulStart = 1'b1;
        step();
        idle_inputs();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();

        // Randomized traffic with small register indices to provoke matches.
        scen = "random";
        for (int i = 0; i < 600; i++) begin
            rst_n           = ($urandom_range(0, 79) != 0);
            bus.EX_MemRead  = ($urandom_range(0, 2) == 0);
            bus.EX_RegWrite = 1'($urandom);
            bus.EX_rdReg    = 5'($urandom_range(0, 3));
            bus.EX_Branch   = ($urandom_range(0, 4) == 0);
            bus.EX_BrTaken  = 1'($urandom);
            bus.EX_Jump     = ($urandom_range(0, 11) == 0);
            bus.EX_MulStart = ($urandom_range(0, 9) == 0);
            bus.ID_rs1Reg   = 5'($urandom_range(0, 3));
            bus.ID_rs2Reg   = 5'($urandom_range(0, 3));
            bus.ID_UsesRs1  = 1'($urandom);
            bus.ID_UsesRs2  = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
